// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue
//
// Fetch stage sitting directly in front of a combinational, byte-addressable
// instruction memory. It holds the fetch PC and drives it out as the memory
// address. Each returned word is captured together with its PC into a small
// FIFO, and the FIFO head is offered to decode over a valid/ready handshake.
// A redirect from branch resolution flushes the queue and reloads the PC.
//
// Parameters:
//   ADDR_W   - PC / instruction memory byte-address width
//   DEPTH    - queue entries (power of two, >= 2)
//   RESET_PC - fetch PC after reset (word aligned)
//
// Ports:
//   clk, rst_n       - clock (rising edge) and async active-low reset
//   Fetch_En         - permits fetching; low freezes the PC and stops pushes
//   Imem_Addr        - byte address to instruction memory (the fetch PC)
//   Imem_Data        - instruction word returned combinationally
//   Redirect_Valid   - taken branch/jump: flush and reload the PC
//   Redirect_Target  - new fetch PC (used as given, no alignment)
//   Out_Valid        - queue head holds a valid instruction
//   Out_Ready        - decode accepts the head this cycle
//   Out_Inst, Out_PC - head instruction word and its PC (zero when empty)
//
// Optional feature (define FETCH_PERF_CNT_EN):
//   Fetch_Count      - 16-bit wrapping count of pushes
//   Stall_Count      - 16-bit wrapping count of cycles that wanted to fetch
//                      but could not (queue full, no pop)
// ---------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int unsigned            ADDR_W   = 8,
    parameter int unsigned            DEPTH    = 4,
    parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Fetch_En,
    output logic [ADDR_W-1:0] Imem_Addr,
    input  logic [31:0]       Imem_Data,
    input  logic              Redirect_Valid,
    input  logic [ADDR_W-1:0] Redirect_Target,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [31:0]       Out_Inst,
    output logic [ADDR_W-1:0] Out_PC
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       Fetch_Count,
    output logic [15:0]       Stall_Count
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [31:0]       inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic push;
    logic pop;

    assign Imem_Addr = fetch_pc;
    assign Out_Valid = (count != '0);
    assign Out_Inst  = Out_Valid ? inst_mem[rd_ptr] : '0;
    assign Out_PC    = Out_Valid ? pc_mem[rd_ptr]   : '0;

    // A full queue can still accept a word when the head leaves in the same
    // cycle, so fetch keeps streaming at one word per cycle under a ready
    // consumer.
    assign pop  = Out_Valid & Out_Ready;
    assign push = Fetch_En & ~Redirect_Valid & ((count < FULL) | pop);

    // Pointers, count and PC. Redirect wins over everything: the handshake
    // in that cycle is still seen by decode, but the entry is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments keep every register updating
            // from pre-edge values, so push/pop decisions stay consistent.
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (Redirect_Valid) begin
            fetch_pc <= Redirect_Target;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);  // wraps at 2^ADDR_W
                wr_ptr   <= wr_ptr + 1'b1;          // power-of-two depth wraps
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Queue storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage is deliberately reset (flops, not RAM) so the
            // queue contents are defined after reset; only DEPTH entries.
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (push) begin
            inst_mem[wr_ptr] <= Imem_Data;
            pc_mem[wr_ptr]   <= fetch_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Performance counters survive redirects; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Fetch_Count <= '0;
            Stall_Count <= '0;
        end else begin
            if (push) begin
                Fetch_Count <= Fetch_Count + 16'd1;
            end
            if (Fetch_En && !Redirect_Valid && !push) begin
                Stall_Count <= Stall_Count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_queue
//
// Directed bench for inst_fetch_queue (ADDR_W=8, DEPTH=4, RESET_PC=0).
// The memory model returns 32'hA5000000 | address. Inputs are driven and
// outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Fetch_En;
    logic [7:0]  Imem_Addr;
    logic [31:0] Imem_Data;
    logic        Redirect_Valid;
    logic [7:0]  Redirect_Target;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Out_Inst;
    logic [7:0]  Out_PC;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] Fetch_Count;
    logic [15:0] Stall_Count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign Imem_Data = 32'hA500_0000 | {24'h0, Imem_Addr};

    inst_fetch_queue #(
        .ADDR_W  (8),
        .DEPTH   (4),
        .RESET_PC(8'h00)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Fetch_En       (Fetch_En),
        .Imem_Addr      (Imem_Addr),
        .Imem_Data      (Imem_Data),
        .Redirect_Valid (Redirect_Valid),
        .Redirect_Target(Redirect_Target),
        .Out_Valid      (Out_Valid),
        .Out_Ready      (Out_Ready),
        .Out_Inst       (Out_Inst),
        .Out_PC         (Out_PC)
`ifdef FETCH_PERF_CNT_EN
        ,
        .Fetch_Count    (Fetch_Count),
        .Stall_Count    (Stall_Count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse that also checks the reset state while reset is held.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(Out_Valid), 32'h0);
        check("rst_addr",  32'(Imem_Addr), 32'h0);
        check("rst_inst",  Out_Inst,       32'h0);
        check("rst_pc",    32'(Out_PC),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b0;
        Fetch_En        = 1'b1;
        Out_Ready       = 1'b1;
        Redirect_Valid  = 1'b0;
        Redirect_Target = 8'h00;

        // ---- streaming with a ready consumer --------------------------------
        do_reset();
        step();
        check("s_valid0", 32'(Out_Valid), 32'h1);
        check("s_pc0",    32'(Out_PC),    32'h0);
        check("s_inst0",  Out_Inst,       32'hA500_0000);
        check("s_addr0",  32'(Imem_Addr), 32'h4);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("s_pc",   32'(Out_PC), 32'(4 * k));
            check("s_inst", Out_Inst,    32'hA500_0000 | 32'(4 * k));
        end

        // ---- fill with consumer stalled ----------------------------------
        Out_Ready = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) step();
        check("f_addr",  32'(Imem_Addr), 32'h10);
        check("f_pc",    32'(Out_PC),    32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("f_hold_addr", 32'(Imem_Addr), 32'h10);
            check("f_hold_pc",   32'(Out_PC),    32'h0);
            check("f_hold_inst", Out_Inst,       32'hA500_0000);
        end
`ifdef FETCH_PERF_CNT_EN
        check("f_fetch_cnt", 32'(Fetch_Count), 32'd4);
        check("f_stall_cnt", 32'(Stall_Count), 32'd3);
`endif

        // ---- full queue, consumer ready: push and pop together ------------
        Out_Ready = 1'b1;
        step();
        check("fp_addr1", 32'(Imem_Addr), 32'h14);
        check("fp_pc1",   32'(Out_PC),    32'h4);
        step();
        check("fp_addr2", 32'(Imem_Addr), 32'h18);
        check("fp_pc2",   32'(Out_PC),    32'h8);
        // Queue still full: PCs 0xC..0x14 queued behind head 0x8 -> drain order.
        Fetch_En = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k < 3) check("fp_drain_pc", 32'(Out_PC), 32'(12 + 4 * k));
            else       check("fp_drain_empty", 32'(Out_Valid), 32'h0);
        end
        check("fp_drain_addr", 32'(Imem_Addr), 32'h18);

        // ---- redirect with three entries queued ---------------------------
        Fetch_En  = 1'b1;
        Out_Ready = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) step();
        check("r_pre_addr", 32'(Imem_Addr), 32'h0C);
        Redirect_Valid  = 1'b1;
        Redirect_Target = 8'h40;
        step();
        Redirect_Valid = 1'b0;
        check("r_valid",  32'(Out_Valid), 32'h0);
        check("r_addr",   32'(Imem_Addr), 32'h40);
        step();
        check("r_valid2", 32'(Out_Valid), 32'h1);
        check("r_pc",     32'(Out_PC),    32'h40);
        check("r_inst",   Out_Inst,       32'hA500_0040);

        // ---- PC wrap at top of address space ------------------------------
        Out_Ready       = 1'b1;
        Redirect_Valid  = 1'b1;
        Redirect_Target = 8'hF8;
        step();
        Redirect_Valid = 1'b0;
        check("w_addr0", 32'(Imem_Addr), 32'hF8);
        step();
        check("w_pc0",   32'(Out_PC),    32'hF8);
        step();
        check("w_pc1",   32'(Out_PC),    32'hFC);
        check("w_inst1", Out_Inst,       32'hA500_00FC);
        check("w_addr1", 32'(Imem_Addr), 32'h00);
        step();
        check("w_pc2",   32'(Out_PC),    32'h00);

        // ---- fetch disabled: drain, then redirect still loads PC ----------
        Fetch_En = 1'b0;
        step();
        check("d_valid", 32'(Out_Valid), 32'h0);
        check("d_addr",  32'(Imem_Addr), 32'h04);
        Redirect_Valid  = 1'b1;
        Redirect_Target = 8'h21;
        step();
        Redirect_Valid = 1'b0;
        check("d_redir_addr", 32'(Imem_Addr), 32'h21);
        Fetch_En = 1'b1;
        step();
        check("d_unaligned_pc", 32'(Out_PC), 32'h21);
        check("d_next_addr",    32'(Imem_Addr), 32'h25);

        // ---- async reset mid-stream with full queue -----------------------
        Out_Ready = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("a_full_valid", 32'(Out_Valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("a_valid", 32'(Out_Valid), 32'h0);
        check("a_addr",  32'(Imem_Addr), 32'h0);
        check("a_pc",    32'(Out_PC),    32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        Out_Ready = 1'b1;
        step();
        check("a_restart_pc",   32'(Out_PC),   32'h0);
        check("a_restart_inst", Out_Inst,      32'hA500_0000);
        step();
        check("a_restart_pc1",  32'(Out_PC),   32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
